// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and stall-counter sizing.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package hazard_pkg;

  // Width of the load-use bubble down-counter
  localparam int LU_CNT_W        = 4;
  // Longest load-use penalty the counter can express
  localparam int MAX_LOAD_STALLS = 15;

  // FSM encoding
  typedef logic [0:0] hz_state_t;
  localparam hz_state_t RUN      = 1'b0;
  localparam hz_state_t LU_STALL = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable, used for performance statistics.
// Latency: count reflects an enabled cycle one clock after it.
// Backpressure: none; once it reaches all-ones it holds there and ignores further enables.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Increment on enable and stop at all-ones so the count never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller beside ID: load-use stalls (LOAD_STALLS bubbles), dmem-wait freeze, taken-branch flush.
// Latency: all pipeline controls are combinational from state, cnt and inputs; stall_cycles lags by one clock.
// Backpressure: dmem_ready=0 freezes every stage and pauses the load-use countdown. Define HAZARD_X0_FILTER_EN so loads to x0 never stall.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_STALLS = 1,
  parameter int PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  dmem_ready,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_write_en,
  output logic                  stall_active,
  output logic [PERF_W-1:0]     stall_cycles
);

  // Out-of-range penalties are clamped to what the 4-bit counter can hold
  localparam int LOAD_STALLS_C = (LOAD_STALLS > MAX_LOAD_STALLS) ? MAX_LOAD_STALLS : LOAD_STALLS;
  // The first bubble is issued from RUN, so LU_STALL covers the remaining ones
  localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LOAD_STALLS_C - 1);

  hz_state_t           state, state_nxt;
  logic [LU_CNT_W-1:0] cnt, cnt_nxt;
  logic                lu_match;
  logic                lu_hit;

  assign lu_match = ex_mem_read &
                    ((id_rs1_used & (id_rs1 == ex_rd)) |
                     (id_rs2_used & (id_rs2 == ex_rd)));

`ifdef HAZARD_X0_FILTER_EN
  // x0 is hard-wired zero, so a load targeting it cannot create a real dependency
  assign lu_hit = lu_match & (ex_rd != '0);
`else
  assign lu_hit = lu_match;
`endif

  // Priority: reset, dmem freeze, branch flush, ongoing load-use stall, new load-use hit, free run
  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    ex_mem_write_en = 1'b1;
    stall_active    = 1'b0;
    state_nxt       = state;
    cnt_nxt         = cnt;
    if (!rst_n) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_bubble    = 1'b1;
      ex_mem_write_en = 1'b0;
    end else if (!dmem_ready) begin
      // Whole pipeline holds; state and cnt keep their values so the stall resumes afterwards
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      stall_active    = 1'b1;
    end else if (branch_taken) begin
      // Wrong-path instructions in IF/ID and ID are discarded, which also cancels any pending stall
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = RUN;
      cnt_nxt      = '0;
    end else if (state == LU_STALL) begin
      // EX holds a bubble here, so a fresh lu_hit cannot occur and is not examined
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
      stall_active   = 1'b1;
      cnt_nxt        = cnt - LU_CNT_W'(1);
      if (cnt == LU_CNT_W'(1)) begin
        state_nxt = RUN;
      end
    end else if (lu_hit) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
      stall_active   = 1'b1;
      if (LOAD_STALLS_C > 1) begin
        state_nxt = LU_STALL;
        cnt_nxt   = LU_RELOAD;
      end
    end
  end

  // FSM state and bubble down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Every cycle in which the PC does not advance is a lost cycle
  sat_counter #(
    .W (PERF_W)
  ) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~pc_write_en),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (1-bubble, 3-bubble, 4-bit counter) share stimulus.
// Latency: outputs are checked combinationally, 2 time units after the driving clock edge.
// Backpressure: freeze behaviour exercised via dmem_ready.
module tb_hazard_ctrl_unit;

  // Packed output view: {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_write_en, stall_active}
  localparam logic [5:0] RUN_O    = 6'b110010;
  localparam logic [5:0] STALL_O  = 6'b000111;
  localparam logic [5:0] FREEZE_O = 6'b000001;
  localparam logic [5:0] FLUSH_O  = 6'b111110;
  localparam logic [5:0] RESET_O  = 6'b000100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, branch_taken, dmem_ready;

  logic [5:0]  o1, o3, os;
  logic [31:0] sc1, sc3;
  logic [3:0]  scs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALLS(1), .PERF_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .pc_write_en(o1[5]), .if_id_write_en(o1[4]), .if_id_flush(o1[3]),
    .id_ex_bubble(o1[2]), .ex_mem_write_en(o1[1]), .stall_active(o1[0]),
    .stall_cycles(sc1)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALLS(3), .PERF_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .pc_write_en(o3[5]), .if_id_write_en(o3[4]), .if_id_flush(o3[3]),
    .id_ex_bubble(o3[2]), .ex_mem_write_en(o3[1]), .stall_active(o3[0]),
    .stall_cycles(sc3)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALLS(1), .PERF_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .pc_write_en(os[5]), .if_id_write_en(os[4]), .if_id_flush(os[3]),
    .id_ex_bubble(os[2]), .ex_mem_write_en(os[1]), .stall_active(os[0]),
    .stall_cycles(scs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
  endtask

  // Advance to 1 unit after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst_n = 1'b0;
    #2;
    check("reset_o1", o1, RESET_O);
    check("reset_o3", o3, RESET_O);
    check("reset_sc1", sc1, 0);
    check("reset_scs", scs, 0);
    nxt();
    rst_n = 1'b1;
    #1;
    check("run_after_reset", o1, RUN_O);

    // Load-use: 1 bubble on u_dut1, 3 on u_dut3
    set_lu(); #1;
    check("lu1_c0", o1, STALL_O);
    check("lu3_c0", o3, STALL_O);
    nxt(); set_idle(); #1;
    check("lu1_c1", o1, RUN_O);
    check("lu3_c1", o3, STALL_O);
    nxt(); #1;
    check("lu3_c2", o3, STALL_O);
    nxt(); #1;
    check("lu3_c3", o3, RUN_O);
    check("lu1_cycles", sc1, 1);
    check("lu3_cycles", sc3, 3);

    // Memory wait during the 2nd bubble
    do_reset();
    set_lu(); #1;
    check("mw_c0", o3, STALL_O);
    nxt(); set_idle(); dmem_ready = 1'b0; #1;
    check("mw_frz0", o3, FREEZE_O);
    check("mw_frz0_d1", o1, FREEZE_O);
    nxt(); #1;
    check("mw_frz1", o3, FREEZE_O);
    nxt(); dmem_ready = 1'b1; #1;
    check("mw_resume0", o3, STALL_O);
    check("mw_d1_run", o1, RUN_O);
    nxt(); #1;
    check("mw_resume1", o3, STALL_O);
    nxt(); #1;
    check("mw_done", o3, RUN_O);
    check("mw_cycles3", sc3, 5);
    check("mw_cycles1", sc1, 3);

    // Flush beats load-use, aborts a pending stall, and loses to a freeze
    do_reset();
    set_lu(); branch_taken = 1'b1; #1;
    check("fl_prio1", o1, FLUSH_O);
    check("fl_prio3", o3, FLUSH_O);
    nxt(); set_idle(); #1;
    check("fl_nostall", o3, RUN_O);
    check("fl_cycles", sc3, 0);
    set_lu(); #1;
    nxt(); set_idle(); branch_taken = 1'b1; #1;
    check("fl_abort", o3, FLUSH_O);
    nxt(); branch_taken = 1'b0; #1;
    check("fl_after_abort", o3, RUN_O);
    check("fl_abort_cycles", sc3, 1);
    branch_taken = 1'b1; dmem_ready = 1'b0; #1;
    check("freeze_over_flush", o3, FREEZE_O);
    set_idle(); #1;

    // Register matching: x0, unused operand, rs2 hit
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1;
    id_rs1 = 5'd3; id_rs1_used = 1'b1; #1;
`ifdef HAZARD_X0_FILTER_EN
    check("x0_load", o1, RUN_O);
`else
    check("x0_load", o1, STALL_O);
`endif
    ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b0; id_rs2 = 5'd9; #1;
    check("unused_rs1", o1, RUN_O);
    ex_rd = 5'd7; id_rs2 = 5'd7; #1;
    check("rs2_hit", o1, STALL_O);
    ex_mem_read = 1'b0; #1;
    check("no_load", o1, RUN_O);

    // Asynchronous reset in the middle of a long stall
    do_reset();
    set_lu(); #1;
    nxt(); set_idle(); #1;
    check("rst_pre", o3, STALL_O);
    rst_n = 1'b0; #1;
    check("rst_async_o3", o3, RESET_O);
    check("rst_async_sc3", sc3, 0);
    nxt();
    rst_n = 1'b1; #1;
    check("rst_no_pending", o3, RUN_O);

    // Saturation of the 4-bit counter
    do_reset();
    dmem_ready = 1'b0;
    repeat (20) nxt();
    check("sat_4bit", scs, 15);
    check("sat_32bit", sc1, 20);
    set_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
